ibex_rvfi_cosim_checker: RTL and testbench
==========================================

IBEX_RVFI_COSIM_CHECKER -- requirements
Module: ibex_rvfi_cosim_checker

Interface
REQ-001 Parameter FifoDepth, default 8: RVFI retire-record buffer depth; power of two, at least 2.
REQ-002 Parameter StopOnMismatch, default 1'b1: 1 = halt comparison on the first mismatch; 0 = continue comparing.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  in  1  core clock.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 clear_i  in  1  synchronous flush: empties buffer, zeroes counters, clears sticky flags.
REQ-007 rvfi_valid_i  in  1  retirement strobe from the core.
REQ-008 rvfi_order_i  in  64  retirement order number.
REQ-009 rvfi_pc_rdata_i / rvfi_insn_i / rvfi_rd_wdata_i  in  32 each  retired PC, instruction word and rd write data.
REQ-010 rvfi_rd_addr_i  in  5  retired destination register; rvfi_trap_i  in  1  retired-with-trap flag.
REQ-011 ref_valid_i  in  1  reference-model entry valid.
REQ-012 ref_ready_o  out  1  entry consumed this cycle.
REQ-013 ref_pc_i / ref_insn_i / ref_rd_wdata_i  in  32 each; ref_rd_addr_i  in  5; ref_trap_i  in  1  expected fields.
REQ-014 cmp_valid_o  out  1  one-cycle pulse: a comparison result is available.
REQ-015 mismatch_o  out  1  one-cycle pulse, qualified by cmp_valid_o: that comparison failed.
REQ-016 match_count_o / mismatch_count_o  out  32 each  result counters.
REQ-017 overflow_o / order_err_o / halted_o  out  1 each  sticky status flags.
REQ-018 diff_pc_o  out  32; diff_mask_o  out  5  first-mismatch detail (see Configuration).

Function
REQ-019 States: RUN and HALT; halted_o = (state == HALT).
REQ-020 A record {pc, insn, rd_addr, rd_wdata, trap} is pushed when rvfi_valid_i = 1 and state == RUN.
REQ-021 A push while the buffer is full and no pop occurs in the same cycle drops the record, sets overflow_o and moves the state to HALT.
REQ-022 Simultaneous push and pop when full is legal: no overflow, occupancy unchanged.
REQ-023 ref_ready_o = (state == RUN) AND (buffer not empty), combinationally.
REQ-024 A compare fires when ref_ready_o AND ref_valid_i: the buffer head is popped in that cycle.
REQ-025 Latency: a record pushed in cycle N is comparable no earlier than N+1; a compare in cycle M yields cmp_valid_o in cycle M+1.
REQ-026 Field compare mask bits: [0] pc, [1] insn, [2] rd_addr, [3] rd_wdata, [4] trap.
REQ-027 rd_wdata is compared only when the reference rd_addr is nonzero; otherwise mask bit [3] = 0.
REQ-028 mismatch_o = OR of the mask bits.
REQ-029 match_count_o or mismatch_count_o increments on each result and saturates at 32'hFFFF_FFFF.
REQ-030 With StopOnMismatch = 1, a mismatch moves the state RUN to HALT in the result cycle; comparisons in flight are not issued after that cycle.
REQ-031 Order check: each pushed rvfi_order_i after the first must equal the previous value + 1 (64-bit wrap-around allowed). Otherwise order_err_o sets; comparison continues.
REQ-032 HALT exits only on clear_i, which returns the state to RUN.
REQ-033 clear_i has priority over a push or compare in the same cycle; cmp_valid_o is suppressed in the following cycle.

Reset
REQ-034 On rst_i assertion, in any state and mid-operation:
- buffer empties;
- state = RUN;
- all counters and sticky flags = 0;
- cmp_valid_o, mismatch_o, diff_pc_o, diff_mask_o = 0;
- the first-order flag is re-armed.
REQ-035 ref_ready_o is 0 throughout reset because the buffer is empty.

Configuration
REQ-036 Macro IBEX_COSIM_DIFF_EN.
- Defined: on the first mismatch after reset or clear_i, diff_pc_o and diff_mask_o latch the reference PC and the field mask, and hold until the next reset or clear_i.
- Undefined: diff_pc_o and diff_mask_o are tied to 0 and no detail registers are instantiated.

Verification
REQ-037 Push 3 records (pc 0x100, 0x104, 0x108) with matching ref entries -> 3 cmp_valid_o pulses, mismatch_o = 0, match_count_o = 3.
REQ-038 Ref rd_wdata 0x5 vs RVFI 0x6, rd_addr 3, StopOnMismatch = 1 -> mismatch_o pulse, mismatch_count_o = 1, halted_o = 1, ref_ready_o = 0 thereafter; with IBEX_COSIM_DIFF_EN defined, diff_mask_o = 5'b01000.
REQ-039 Same data difference with rd_addr 0 -> match, diff_mask_o stays 0.
REQ-040 Hold ref_valid_i = 0 and push 9 records with FifoDepth = 8 -> overflow_o = 1, halted_o = 1; pulse clear_i -> all flags and counters 0, state RUN.
REQ-041 rvfi_order sequence 5, 6, 8 -> order_err_o = 1 after the third push; comparisons continue.
REQ-042 Assert rst_i with 4 records buffered and a compare in flight -> next cycle cmp_valid_o = 0, ref_ready_o = 0, counters 0.

Source files
------------

// File: rtl/ibex_rvfi_cosim_checker_if.sv
// ibex_rvfi_cosim_checker_if: bundles the flush, RVFI retire, reference-model and result/status
//   signals of the cosim checker. Clock and reset remain plain ports on the checker itself.
// Modports: master = environment side (drives RVFI/reference/clear, observes results),
//   slave = checker side.
interface ibex_rvfi_cosim_checker_if;
  logic        clear_i;

  logic        rvfi_valid_i;
  logic [63:0] rvfi_order_i;
  logic [31:0] rvfi_pc_rdata_i;
  logic [31:0] rvfi_insn_i;
  logic [4:0]  rvfi_rd_addr_i;
  logic [31:0] rvfi_rd_wdata_i;
  logic        rvfi_trap_i;

  logic        ref_valid_i;
  logic        ref_ready_o;
  logic [31:0] ref_pc_i;
  logic [31:0] ref_insn_i;
  logic [4:0]  ref_rd_addr_i;
  logic [31:0] ref_rd_wdata_i;
  logic        ref_trap_i;

  logic        cmp_valid_o;
  logic        mismatch_o;
  logic [31:0] match_count_o;
  logic [31:0] mismatch_count_o;
  logic        overflow_o;
  logic        order_err_o;
  logic        halted_o;
  logic [31:0] diff_pc_o;
  logic [4:0]  diff_mask_o;

  modport master (
    output clear_i,
    output rvfi_valid_i, rvfi_order_i, rvfi_pc_rdata_i, rvfi_insn_i,
    output rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_trap_i,
    output ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i, ref_rd_wdata_i, ref_trap_i,
    input  ref_ready_o,
    input  cmp_valid_o, mismatch_o, match_count_o, mismatch_count_o,
    input  overflow_o, order_err_o, halted_o, diff_pc_o, diff_mask_o
  );

  modport slave (
    input  clear_i,
    input  rvfi_valid_i, rvfi_order_i, rvfi_pc_rdata_i, rvfi_insn_i,
    input  rvfi_rd_addr_i, rvfi_rd_wdata_i, rvfi_trap_i,
    input  ref_valid_i, ref_pc_i, ref_insn_i, ref_rd_addr_i, ref_rd_wdata_i, ref_trap_i,
    output ref_ready_o,
    output cmp_valid_o, mismatch_o, match_count_o, mismatch_count_o,
    output overflow_o, order_err_o, halted_o, diff_pc_o, diff_mask_o
  );
endinterface

// File: rtl/ibex_rvfi_cosim_checker.sv
// ibex_rvfi_cosim_checker: buffers RVFI retire records and compares each one field-by-field
//   against the reference-model stream, keeping result counters and sticky status flags.
// Latency: a record is comparable the cycle after its push; a compare yields cmp_valid_o one cycle later.
// Backpressure: ref_ready_o only while running with a buffered record; RVFI cannot be stalled, so a
//   push into a full buffer (with no pop that cycle) drops the record, sets overflow_o and halts.
// Ports: clk_i, rst_i (asynchronous, active-high); bus (slave modport) carries clear_i, RVFI
//   retire fields, reference entry + ref_ready_o, and all result/status outputs.
// Parameters: FifoDepth (power of two, >= 2), StopOnMismatch (halt on first mismatch).
// Optional feature macro IBEX_COSIM_DIFF_EN: latch reference PC and field mask of the first mismatch
//   on diff_pc_o/diff_mask_o; when undefined both outputs are tied to zero.
module ibex_rvfi_cosim_checker #(
  parameter int unsigned FifoDepth      = 8,
  parameter bit          StopOnMismatch = 1'b1
) (
  input logic                      clk_i,
  input logic                      rst_i,
  ibex_rvfi_cosim_checker_if.slave bus
);
  localparam int unsigned AW = $clog2(FifoDepth);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
  } rec_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rec_t        mem_q [FifoDepth];
  rec_t        mem_d [FifoDepth];
  logic        cmp_valid_q, cmp_valid_d;
  logic        mismatch_q, mismatch_d;
  logic [31:0] match_cnt_q, match_cnt_d;
  logic [31:0] mismatch_cnt_q, mismatch_cnt_d;
  logic        overflow_q, overflow_d;
  logic        order_err_q, order_err_d;
  logic        order_seen_q, order_seen_d;
  logic [63:0] prev_order_q, prev_order_d;

  logic        running, empty, full, pop, push_req, mism;
  logic [4:0]  mask;
  rec_t        head, push_rec;

  assign running  = (state_q == RUN);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign bus.ref_ready_o = running && !empty;
  // clear_i wins over any push or compare issued in the same cycle.
  assign pop      = running && !empty && bus.ref_valid_i && !bus.clear_i;
  assign push_req = running && bus.rvfi_valid_i && !bus.clear_i;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign push_rec = '{pc: bus.rvfi_pc_rdata_i, insn: bus.rvfi_insn_i, rd_addr: bus.rvfi_rd_addr_i,
                      rd_wdata: bus.rvfi_rd_wdata_i, trap: bus.rvfi_trap_i};

  always_comb begin
    mask    = '0;
    mask[0] = (head.pc != bus.ref_pc_i);
    mask[1] = (head.insn != bus.ref_insn_i);
    mask[2] = (head.rd_addr != bus.ref_rd_addr_i);
    // Writes to x0 are architecturally discarded, so their data is not meaningful.
    mask[3] = (bus.ref_rd_addr_i != 5'd0) && (head.rd_wdata != bus.ref_rd_wdata_i);
    mask[4] = (head.trap != bus.ref_trap_i);
  end

  assign mism = |mask;

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    mem_d          = mem_q;
    cmp_valid_d    = 1'b0;
    mismatch_d     = 1'b0;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    overflow_d     = overflow_q;
    order_err_d    = order_err_q;
    order_seen_d   = order_seen_q;
    prev_order_d   = prev_order_q;

    if (bus.clear_i) begin
      state_d        = RUN;
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      match_cnt_d    = '0;
      mismatch_cnt_d = '0;
      overflow_d     = 1'b0;
      order_err_d    = 1'b0;
      order_seen_d   = 1'b0;
      prev_order_d   = '0;
    end else begin
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + 1'b1;
        cmp_valid_d = 1'b1;
        mismatch_d  = mism;
        if (mism) begin
          if (mismatch_cnt_q != 32'hFFFF_FFFF) mismatch_cnt_d = mismatch_cnt_q + 32'd1;
          // Halting here makes HALT visible in the result cycle, so no further compare is issued.
          if (StopOnMismatch) state_d = HALT;
        end else begin
          if (match_cnt_q != 32'hFFFF_FFFF) match_cnt_d = match_cnt_q + 32'd1;
        end
      end

      if (push_req) begin
        // A pop in the same cycle frees a slot, so a full buffer can still accept.
        if (full && !pop) begin
          overflow_d = 1'b1;
          state_d    = HALT;
        end else begin
          mem_d[wr_ptr_q[AW-1:0]] = push_rec;
          wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (order_seen_q && (bus.rvfi_order_i != prev_order_q + 64'd1)) order_err_d = 1'b1;
        order_seen_d = 1'b1;
        prev_order_d = bus.rvfi_order_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      cmp_valid_q    <= 1'b0;
      mismatch_q     <= 1'b0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      overflow_q     <= 1'b0;
      order_err_q    <= 1'b0;
      order_seen_q   <= 1'b0;
      prev_order_q   <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_q          <= mem_d;
      cmp_valid_q    <= cmp_valid_d;
      mismatch_q     <= mismatch_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      overflow_q     <= overflow_d;
      order_err_q    <= order_err_d;
      order_seen_q   <= order_seen_d;
      prev_order_q   <= prev_order_d;
    end
  end

  assign bus.cmp_valid_o      = cmp_valid_q;
  assign bus.mismatch_o       = mismatch_q;
  assign bus.match_count_o    = match_cnt_q;
  assign bus.mismatch_count_o = mismatch_cnt_q;
  assign bus.overflow_o       = overflow_q;
  assign bus.order_err_o      = order_err_q;
  assign bus.halted_o         = (state_q == HALT);

`ifdef IBEX_COSIM_DIFF_EN
  logic [31:0] diff_pc_q, diff_pc_d;
  logic [4:0]  diff_mask_q, diff_mask_d;
  logic        diff_lock_q, diff_lock_d;

  always_comb begin
    diff_pc_d   = diff_pc_q;
    diff_mask_d = diff_mask_q;
    diff_lock_d = diff_lock_q;
    if (bus.clear_i) begin
      diff_pc_d   = '0;
      diff_mask_d = '0;
      diff_lock_d = 1'b0;
    end else if (pop && mism && !diff_lock_q) begin
      // Only the first mismatch is kept; later ones leave the detail untouched.
      diff_pc_d   = bus.ref_pc_i;
      diff_mask_d = mask;
      diff_lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      diff_pc_q   <= '0;
      diff_mask_q <= '0;
      diff_lock_q <= 1'b0;
    end else begin
      diff_pc_q   <= diff_pc_d;
      diff_mask_q <= diff_mask_d;
      diff_lock_q <= diff_lock_d;
    end
  end

  assign bus.diff_pc_o   = diff_pc_q;
  assign bus.diff_mask_o = diff_mask_q;
`else
  assign bus.diff_pc_o   = '0;
  assign bus.diff_mask_o = '0;
`endif
endmodule

// File: tb/tb_ibex_rvfi_cosim_checker.sv
// tb_ibex_rvfi_cosim_checker: directed scenarios with literal expectations plus randomized traffic,
//   all outputs checked every cycle against a queue-based behavioural model of the checker.
module tb_ibex_rvfi_cosim_checker;
  localparam int unsigned DEPTH = 8;
  localparam bit          STOP  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        trap;
  } trec_t;

  logic clk_i = 1'b0;
  logic rst_i;

  ibex_rvfi_cosim_checker_if bus ();

  ibex_rvfi_cosim_checker #(
    .FifoDepth     (DEPTH),
    .StopOnMismatch(STOP)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  int          checks      = 0;
  int          failures    = 0;
  int          pulses      = 0;
  int          mism_pulses = 0;
  logic [31:0] pc_ctr      = 32'h0;
  logic [63:0] next_order  = 64'd0;

  // Behavioural model state
  trec_t       m_q[$];
  bit          m_halted, m_ovf, m_oerr, m_cmp_valid, m_mis, m_seen, m_lock;
  logic [31:0] m_match = '0, m_mism = '0, m_dpc = '0;
  logic [4:0]  m_dmask = '0;
  logic [63:0] m_prev  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] fmask(input trec_t h, input trec_t r);
    logic [4:0] m;
    m[0] = (h.pc != r.pc);
    m[1] = (h.insn != r.insn);
    m[2] = (h.rd != r.rd);
    m[3] = (r.rd != 5'd0) && (h.wd != r.wd);
    m[4] = (h.trap != r.trap);
    return m;
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_halted = 0; m_ovf = 0; m_oerr = 0; m_cmp_valid = 0; m_mis = 0; m_seen = 0; m_lock = 0;
    m_match = '0; m_mism = '0; m_dpc = '0; m_dmask = '0; m_prev = '0;
  endfunction

  task automatic model_step();
    trec_t      r, p;
    logic [4:0] mk;
    bit         do_pop, do_push;
    do_pop  = !m_halted && (m_q.size() != 0) && bus.ref_valid_i;
    do_push = !m_halted && bus.rvfi_valid_i;
    m_cmp_valid = do_pop;
    m_mis       = 0;
    if (do_pop) begin
      r.pc = bus.ref_pc_i; r.insn = bus.ref_insn_i; r.rd = bus.ref_rd_addr_i;
      r.wd = bus.ref_rd_wdata_i; r.trap = bus.ref_trap_i;
      mk    = fmask(m_q[0], r);
      m_mis = (mk != 5'd0);
      if (m_mis) begin
        if (m_mism != 32'hFFFF_FFFF) m_mism = m_mism + 32'd1;
        if (!m_lock) begin m_lock = 1; m_dpc = r.pc; m_dmask = mk; end
      end else if (m_match != 32'hFFFF_FFFF) m_match = m_match + 32'd1;
      void'(m_q.pop_front());
    end
    if (do_push) begin
      p.pc = bus.rvfi_pc_rdata_i; p.insn = bus.rvfi_insn_i; p.rd = bus.rvfi_rd_addr_i;
      p.wd = bus.rvfi_rd_wdata_i; p.trap = bus.rvfi_trap_i;
      if (m_q.size() >= DEPTH) begin m_ovf = 1; m_halted = 1; end
      else m_q.push_back(p);
      if (m_seen && (bus.rvfi_order_i != m_prev + 64'd1)) m_oerr = 1;
      m_seen = 1;
      m_prev = bus.rvfi_order_i;
    end
    if (m_mis && STOP) m_halted = 1;
  endtask

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) model_clear();
    else if (bus.clear_i) model_clear();
    else model_step();
  end

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk_i) begin
    chk("ref_ready", bus.ref_ready_o, !m_halted && (m_q.size() != 0));
    chk("cmp_valid", bus.cmp_valid_o, m_cmp_valid);
    if (m_cmp_valid) chk("mismatch", bus.mismatch_o, m_mis);
    chk("match_count", bus.match_count_o, m_match);
    chk("mismatch_count", bus.mismatch_count_o, m_mism);
    chk("overflow", bus.overflow_o, m_ovf);
    chk("order_err", bus.order_err_o, m_oerr);
    chk("halted", bus.halted_o, m_halted);
`ifdef IBEX_COSIM_DIFF_EN
    chk("diff_pc", bus.diff_pc_o, m_dpc);
    chk("diff_mask", bus.diff_mask_o, m_dmask);
`else
    chk("diff_pc", bus.diff_pc_o, 64'd0);
    chk("diff_mask", bus.diff_mask_o, 64'd0);
`endif
  end

  task automatic zero_inputs();
    bus.clear_i = 0; bus.rvfi_valid_i = 0; bus.rvfi_order_i = '0; bus.rvfi_pc_rdata_i = '0;
    bus.rvfi_insn_i = '0; bus.rvfi_rd_addr_i = '0; bus.rvfi_rd_wdata_i = '0; bus.rvfi_trap_i = 0;
    bus.ref_valid_i = 0; bus.ref_pc_i = '0; bus.ref_insn_i = '0; bus.ref_rd_addr_i = '0;
    bus.ref_rd_wdata_i = '0; bus.ref_trap_i = 0;
  endtask

  // Sets inputs for the coming cycle; the reference entry mirrors the model's buffer head.
  task automatic prep(input bit push, input bit rv, input bit corrupt, input bit clr);
    trec_t h;
    int    k;
    bus.clear_i      = clr;
    bus.rvfi_valid_i = push;
    if (push) begin
      pc_ctr               = pc_ctr + 32'd4;
      bus.rvfi_pc_rdata_i  = pc_ctr;
      bus.rvfi_insn_i      = $urandom;
      bus.rvfi_rd_addr_i   = 5'($urandom_range(0, 31));
      bus.rvfi_rd_wdata_i  = $urandom;
      bus.rvfi_trap_i      = ($urandom_range(0, 15) == 0);
      bus.rvfi_order_i     = next_order;
      next_order           = next_order + 64'd1;
    end
    bus.ref_valid_i = rv;
    if (m_q.size() != 0) h = m_q[0];
    else begin
      h.pc = $urandom; h.insn = $urandom; h.rd = 5'($urandom_range(0, 31));
      h.wd = $urandom; h.trap = $urandom_range(0, 1) == 1;
    end
    if (corrupt) begin
      k = int'($urandom_range(0, 4));
      case (k)
        0:       h.pc = h.pc ^ 32'h4;
        1:       h.insn = h.insn ^ (32'h1 << $urandom_range(0, 31));
        2:       h.rd = h.rd ^ 5'h1;
        3:       h.wd = h.wd ^ 32'h80;
        default: h.trap = ~h.trap;
      endcase
    end
    bus.ref_pc_i = h.pc; bus.ref_insn_i = h.insn; bus.ref_rd_addr_i = h.rd;
    bus.ref_rd_wdata_i = h.wd; bus.ref_trap_i = h.trap;
  endtask

  // Advance one cycle; returns #1 after the edge so registered results are settled.
  task automatic tick();
    @(negedge clk_i);
    if (bus.cmp_valid_o === 1'b1) begin
      pulses++;
      if (bus.mismatch_o === 1'b1) mism_pulses++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input bit push, input bit rv, input bit corrupt, input bit clr);
    prep(push, rv, corrupt, clr);
    tick();
  endtask

  int p0, mp0, rvp;
  bit clr;

  initial begin
    zero_inputs();
    rst_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ref_ready", bus.ref_ready_o, 64'd0);
    chk("rst_match_count", bus.match_count_o, 64'd0);
    chk("rst_cmp_valid", bus.cmp_valid_o, 64'd0);
    chk("rst_halted", bus.halted_o, 64'd0);
    rst_i = 1'b0;

    // Three matching records at pc 0x100/0x104/0x108
    pc_ctr = 32'hFC;
    p0 = pulses; mp0 = mism_pulses;
    cyc(1, 1, 0, 0);
    chk("model_pc0", m_q[0].pc, 64'h100);
    repeat (2) cyc(1, 1, 0, 0);
    repeat (4) cyc(0, 1, 0, 0);
    chk("three_pulses", pulses - p0, 64'd3);
    chk("three_no_mism", mism_pulses - mp0, 64'd0);
    chk("three_match_count", bus.match_count_o, 64'd3);

    // rd_wdata difference on rd 3: mismatch, halt, ref_ready drops with a record still buffered
    cyc(0, 0, 0, 1);
    prep(1, 0, 0, 0); bus.rvfi_rd_addr_i = 5'd3; bus.rvfi_rd_wdata_i = 32'h6; tick();
    prep(1, 1, 0, 0); bus.ref_rd_wdata_i = 32'h5; tick();
    chk("wd_cmp_valid", bus.cmp_valid_o, 64'd1);
    chk("wd_mismatch", bus.mismatch_o, 64'd1);
    chk("wd_mismatch_count", bus.mismatch_count_o, 64'd1);
    chk("wd_halted", bus.halted_o, 64'd1);
    chk("wd_ref_ready", bus.ref_ready_o, 64'd0);
`ifdef IBEX_COSIM_DIFF_EN
    chk("wd_diff_mask", bus.diff_mask_o, 64'h08);
`else
    chk("wd_diff_mask", bus.diff_mask_o, 64'h00);
`endif
    cyc(0, 1, 0, 0);
    chk("wd_no_more_cmp", bus.cmp_valid_o, 64'd0);

    // Same data difference on rd 0: still a match
    cyc(0, 0, 0, 1);
    prep(1, 0, 0, 0); bus.rvfi_rd_addr_i = 5'd0; bus.rvfi_rd_wdata_i = 32'h6; tick();
    prep(0, 1, 0, 0); bus.ref_rd_wdata_i = 32'h5; tick();
    chk("x0_cmp_valid", bus.cmp_valid_o, 64'd1);
    chk("x0_mismatch", bus.mismatch_o, 64'd0);
    chk("x0_match_count", bus.match_count_o, 64'd1);
    chk("x0_diff_mask", bus.diff_mask_o, 64'd0);

    // Overflow: nine pushes into an eight-deep buffer with no reference entries
    cyc(0, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);
    chk("full_no_overflow", bus.overflow_o, 64'd0);
    cyc(1, 0, 0, 0);
    chk("ovf_overflow", bus.overflow_o, 64'd1);
    chk("ovf_halted", bus.halted_o, 64'd1);
    cyc(0, 0, 0, 1);
    chk("clr_overflow", bus.overflow_o, 64'd0);
    chk("clr_halted", bus.halted_o, 64'd0);
    chk("clr_match_count", bus.match_count_o, 64'd0);
    chk("clr_mismatch_count", bus.mismatch_count_o, 64'd0);
    chk("clr_ref_ready", bus.ref_ready_o, 64'd0);

    // Order sequence 5, 6, 8
    next_order = 64'd5;
    repeat (2) cyc(1, 0, 0, 0);
    chk("order_ok", bus.order_err_o, 64'd0);
    next_order = 64'd8;
    cyc(1, 0, 0, 0);
    chk("order_err", bus.order_err_o, 64'd1);
    repeat (5) cyc(0, 1, 0, 0);
    chk("order_match_count", bus.match_count_o, 64'd3);
    chk("order_not_halted", bus.halted_o, 64'd0);

    // Reset with four records buffered and a compare in flight
    cyc(0, 0, 0, 1);
    repeat (4) cyc(1, 0, 0, 0);
    chk("pre_rst_ref_ready", bus.ref_ready_o, 64'd1);
    cyc(0, 1, 0, 0);
    chk("inflight_cmp", bus.cmp_valid_o, 64'd1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_cmp_valid", bus.cmp_valid_o, 64'd0);
    chk("mid_rst_ref_ready", bus.ref_ready_o, 64'd0);
    chk("mid_rst_match_count", bus.match_count_o, 64'd0);
    prep(0, 0, 0, 0);
    tick();
    rst_i = 1'b0;

    // Randomized traffic, including 64-bit order wrap and clears that resume from HALT
    cyc(0, 0, 0, 1);
    next_order = 64'hFFFF_FFFF_FFFF_FFFE;
    for (int i = 0; i < 1600; i++) begin
      rvp = (i < 800) ? 65 : 25;
      clr = ($urandom_range(0, 199) == 0) || (m_halted && ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 99) < 3) next_order = next_order + 64'd2;
      cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < rvp, $urandom_range(0, 99) < 10, clr);
    end
    repeat (3) cyc(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
